// File: rtl/load_store_unit_if.sv
// load_store_unit_if
//   Bundles the CPU-side request/response handshake and the data-memory
//   port of the load/store unit.
//   slave  : the load/store unit (accepts requests, drives the memory).
//   master : the requester / memory side (testbench or CPU + DMem).
//   req_*  : one request at a time, valid/ready handshake.
//   resp_* : one-cycle response pulse, no backpressure.
//   mem_*  : big-endian 16-bit memory, combinational read, posedge write.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        resp_valid;
  logic [15:0] resp_rdata;
  logic        resp_err;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [15:0] mem_rdata;

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_addr, mem_wdata, mem_read, mem_write
  );

  modport master (
    output req_valid, req_op, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_addr, mem_wdata, mem_read, mem_write
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit
//   Multi-cycle load/store initiator between the CPU datapath and a
//   byte-addressed, big-endian 16-bit data memory. Byte stores are done as
//   read-modify-write because the memory only writes whole words.
//   Ports:
//     clk  : system clock
//     rst  : asynchronous active-high reset
//     bus  : load_store_unit_if.slave (request, response, memory port)
//   Ops: 000 LW, 001 LB, 010 LBU, 011 SW, 100 SB; others rejected.
//   Latency (accept edge -> resp_valid): error 1, loads 2, SW 2, SB 3.
module load_store_unit #(
  parameter int MEM_BYTES = 256
) (
  input logic                clk,
  input logic                rst,
  load_store_unit_if.slave   bus
);

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LB  = 3'd1;
  localparam logic [2:0] OP_LBU = 3'd2;
  localparam logic [2:0] OP_SW  = 3'd3;
  localparam logic [2:0] OP_SB  = 3'd4;

  // Last valid byte address.
  localparam logic [15:0] LAST_A = 16'(MEM_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  op_q;
  logic [15:0] addr_q;
  logic [15:0] wdata_q;
  logic [15:0] rbuf_q;
  logic [15:0] rdata_q;
  logic        err_q;

  // Combinational outputs, mapped onto the interface below.
  logic        req_ready_o;
  logic        resp_valid_o;
  logic [15:0] resp_rdata_o;
  logic        resp_err_o;
  logic [15:0] mem_addr_o;
  logic [15:0] mem_wdata_o;
  logic        mem_read_o;
  logic        mem_write_o;

  // ---------------------------------------------------------------------
  // Request decode (acceptance side)
  // ---------------------------------------------------------------------
  logic accept;
  logic req_word;
  logic req_err;

  assign accept   = bus.req_valid & req_ready_o;
  assign req_word = (bus.req_op == OP_LW) | (bus.req_op == OP_SW);
  // Word ops need addr and addr+1 in range; byte ops only addr.
  assign req_err  = (bus.req_op > OP_SB)
                  | (bus.req_addr > LAST_A)
                  | (req_word & (bus.req_addr >= LAST_A));

  // ---------------------------------------------------------------------
  // Captured-request decode
  // ---------------------------------------------------------------------
  logic        is_byte_q;
  logic        low_lane;
  logic [15:0] base;
  logic [7:0]  rd_byte;
  logic [15:0] load_res;
  logic [15:0] sb_word;

  assign is_byte_q = (op_q == OP_LB) | (op_q == OP_LBU) | (op_q == OP_SB);
  // A byte at the very last address is reached through the word one below
  // it, so the access never touches M[MEM_BYTES].
  assign low_lane  = is_byte_q & (addr_q == LAST_A);
  assign base      = low_lane ? (addr_q - 16'd1) : addr_q;
  assign rd_byte   = low_lane ? bus.mem_rdata[7:0] : bus.mem_rdata[15:8];

  always_comb begin
    load_res = 16'h0000;
    case (op_q)
      OP_LW:   load_res = bus.mem_rdata;
      OP_LB:   load_res = {{8{rd_byte[7]}}, rd_byte};
      OP_LBU:  load_res = {8'h00, rd_byte};
      default: load_res = 16'h0000;
    endcase
  end

  // Merge the new byte into the word read back during RD.
  assign sb_word = low_lane ? {rbuf_q[15:8], wdata_q[7:0]}
                            : {wdata_q[7:0], rbuf_q[7:0]};

  // ---------------------------------------------------------------------
  // FSM: next state and outputs
  // ---------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    req_ready_o  = 1'b0;
    resp_valid_o = 1'b0;
    resp_rdata_o = 16'h0000;
    resp_err_o   = 1'b0;
    mem_addr_o   = 16'h0000;
    mem_wdata_o  = 16'h0000;
    mem_read_o   = 1'b0;
    mem_write_o  = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (bus.req_valid) begin
          if (req_err)                   state_d = RESP;
          else if (bus.req_op == OP_SW)  state_d = WR;
          else                           state_d = RD;
        end
      end
      RD: begin
        mem_read_o = 1'b1;
        mem_addr_o = base;
        state_d    = (op_q == OP_SB) ? WR : RESP;
      end
      WR: begin
        mem_write_o = 1'b1;
        mem_addr_o  = base;
        mem_wdata_o = (op_q == OP_SW) ? wdata_q : sb_word;
        state_d     = RESP;
      end
      RESP: begin
        resp_valid_o = 1'b1;
        resp_rdata_o = rdata_q;
        resp_err_o   = err_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Reset silences everything immediately, including a write strobe in
    // flight, so nothing lands at the next edge.
    if (rst) begin
      state_d      = IDLE;
      req_ready_o  = 1'b0;
      resp_valid_o = 1'b0;
      resp_rdata_o = 16'h0000;
      resp_err_o   = 1'b0;
      mem_addr_o   = 16'h0000;
      mem_wdata_o  = 16'h0000;
      mem_read_o   = 1'b0;
      mem_write_o  = 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= 3'd0;
      addr_q  <= 16'h0000;
      wdata_q <= 16'h0000;
      rbuf_q  <= 16'h0000;
      rdata_q <= 16'h0000;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q    <= bus.req_op;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        err_q   <= req_err;
        rbuf_q  <= 16'h0000;
        rdata_q <= 16'h0000;
      end
      if (state_q == RD) begin
        rbuf_q  <= bus.mem_rdata;
        // Stores leave rdata_q at 0 (load_res is 0 for non-load ops).
        rdata_q <= load_res;
      end
    end
  end

  assign bus.req_ready  = req_ready_o;
  assign bus.resp_valid = resp_valid_o;
  assign bus.resp_rdata = resp_rdata_o;
  assign bus.resp_err   = resp_err_o;
  assign bus.mem_addr   = mem_addr_o;
  assign bus.mem_wdata  = mem_wdata_o;
  assign bus.mem_read   = mem_read_o;
  assign bus.mem_write  = mem_write_o;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit
//   Scoreboard bench: each request pushes its expected response (from a
//   byte-level reference memory) and the monitor pops/compares on resp_valid.
module tb_load_store_unit;

  localparam int MB = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  load_store_unit_if bus ();

  load_store_unit #(.MEM_BYTES(MB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- memory model ----------------
  logic [7:0] mem     [0:MB-1];
  logic [7:0] ref_mem [0:MB-1];

  function automatic logic [7:0] rdb(input int a);
    return (a < MB) ? mem[a] : 8'h00;
  endfunction

  assign bus.mem_rdata = {rdb(int'(bus.mem_addr)), rdb(int'(bus.mem_addr) + 1)};

  always @(posedge clk) begin
    if (bus.mem_write) begin
      if (int'(bus.mem_addr) < MB)     mem[bus.mem_addr]      <= bus.mem_wdata[15:8];
      if (int'(bus.mem_addr) + 1 < MB) mem[bus.mem_addr + 1] <= bus.mem_wdata[7:0];
    end
  end

  // ---------------- checking ----------------
  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic        err;
    logic [15:0] rdata;
    int          lat;
    int          nrd;
    int          nwr;
    logic [15:0] addr;
    logic [15:0] wdata;
  } exp_t;

  exp_t sb[$];
  int cyc = 0;
  int acc_cyc = 0;
  int nrd_cnt = 0;
  int nwr_cnt = 0;
  logic [15:0] seen_addr = 16'h0;
  logic [15:0] seen_wdata = 16'h0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference behaviour of one request; updates ref_mem for stores.
  function automatic exp_t model(input logic [2:0] op, input logic [15:0] a,
                                 input logic [15:0] w);
    exp_t e;
    logic word;
    logic low;
    int ai;
    e = '{err: 1'b0, rdata: 16'h0, lat: 1, nrd: 0, nwr: 0, addr: 16'h0, wdata: 16'h0};
    ai   = int'(a);
    word = (op == 3'd0) || (op == 3'd3);
    if (op > 3'd4 || ai >= MB || (word && ai > MB - 2)) begin
      e.err = 1'b1;
      return e;
    end
    low    = !word && (ai == MB - 1);
    e.addr = low ? a - 16'd1 : a;
    case (op)
      3'd0: begin e.lat = 2; e.nrd = 1; e.rdata = {ref_mem[ai], ref_mem[ai+1]}; end
      3'd1: begin e.lat = 2; e.nrd = 1; e.rdata = {{8{ref_mem[ai][7]}}, ref_mem[ai]}; end
      3'd2: begin e.lat = 2; e.nrd = 1; e.rdata = {8'h00, ref_mem[ai]}; end
      3'd3: begin
        e.lat = 2; e.nwr = 1; e.wdata = w;
        ref_mem[ai] = w[15:8]; ref_mem[ai+1] = w[7:0];
      end
      default: begin
        e.lat = 3; e.nrd = 1; e.nwr = 1;
        e.wdata = low ? {ref_mem[ai-1], w[7:0]} : {w[7:0], ref_mem[ai+1]};
        ref_mem[ai] = w[7:0];
      end
    endcase
    return e;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mem_read && bus.mem_write) chk("rw_excl", 1, 0);
      if (bus.mem_read)  begin nrd_cnt++; seen_addr = bus.mem_addr; end
      if (bus.mem_write) begin nwr_cnt++; seen_addr = bus.mem_addr; seen_wdata = bus.mem_wdata; end
      if (!bus.mem_read && !bus.mem_write) begin
        chk("maddr_idle", bus.mem_addr, 0);
        chk("mwdata_idle", bus.mem_wdata, 0);
      end
      if (bus.resp_valid) begin
        if (sb.size() == 0) begin
          chk("unexp_resp", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("err", bus.resp_err, e.err);
          chk("rdata", bus.resp_rdata, e.rdata);
          chk("lat", cyc - acc_cyc, e.lat);
          chk("nrd", nrd_cnt, e.nrd);
          chk("nwr", nwr_cnt, e.nwr);
          if (e.nrd + e.nwr > 0) chk("maddr", seen_addr, e.addr);
          if (e.nwr > 0)         chk("mwdata", seen_wdata, e.wdata);
        end
      end else begin
        chk("rdata_idle", bus.resp_rdata, 0);
      end
    end
  end

  // ---------------- driver ----------------
  task automatic do_req(input logic [2:0] op, input logic [15:0] a, input logic [15:0] w);
    exp_t e;
    int n;
    e = model(op, a, w);
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
    if (!bus.req_ready) begin
      chk("ready_to", 0, 1);
      return;
    end
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_addr = a; bus.req_wdata = w;
    @(posedge clk);
    acc_cyc = cyc;
    nrd_cnt = 0;
    nwr_cnt = 0;
    sb.push_back(e);
    @(negedge clk);
    // Scramble inputs: the unit must have sampled them on the accept edge.
    bus.req_valid = 1'b0;
    bus.req_op    = 3'($urandom);
    bus.req_addr  = 16'($urandom);
    bus.req_wdata = 16'($urandom);
    n = 0;
    while (sb.size() != 0 && n < 10) begin @(posedge clk); n++; end
    if (sb.size() != 0) begin
      chk("resp_to", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic chk_mem(input string tag, input int a);
    chk(tag, mem[a], ref_mem[a]);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] old_hi;
    logic [7:0] old_lo;
    int n;
    for (int i = 0; i < MB; i++) begin mem[i] = 8'h00; ref_mem[i] = 8'h00; end
    bus.req_valid = 1'b1;
    bus.req_op    = 3'd0;
    bus.req_addr  = 16'h0;
    bus.req_wdata = 16'h0;

    // Reset state: a valid request during reset must not be accepted.
    repeat (3) @(negedge clk);
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_rvalid", bus.resp_valid, 0);
    chk("rst_rerr", bus.resp_err, 0);
    chk("rst_rdata", bus.resp_rdata, 0);
    chk("rst_mread", bus.mem_read, 0);
    chk("rst_mwrite", bus.mem_write, 0);
    chk("rst_maddr", bus.mem_addr, 0);
    chk("rst_mwdata", bus.mem_wdata, 0);
    bus.req_valid = 1'b0;
    rst = 1'b0;

    // SW / LW word round trip.
    do_req(3'd3, 16'h0010, 16'hBEEF);
    chk_mem("m10", 'h10);
    chk_mem("m11", 'h11);
    chk("m10_val", mem['h10], 8'hBE);
    do_req(3'd0, 16'h0010, 16'h0);

    // SB as read-modify-write, high lane.
    do_req(3'd4, 16'h0011, 16'h005A);
    do_req(3'd0, 16'h0010, 16'h0);
    chk("m11_sb", mem['h11], 8'h5A);

    // Sign / zero extension.
    do_req(3'd4, 16'h0020, 16'h0080);
    do_req(3'd1, 16'h0020, 16'h0);
    do_req(3'd2, 16'h0020, 16'h0);

    // Last byte: low lane via base 0xFE, M[0xFE] untouched.
    do_req(3'd4, 16'h00FE, 16'h0033);
    do_req(3'd4, 16'h00FF, 16'h0077);
    chk("mfe_keep", mem['hFE], 8'h33);
    chk("mff_sb", mem['hFF], 8'h77);
    do_req(3'd2, 16'h00FF, 16'h0);
    do_req(3'd1, 16'h00FF, 16'h0);
    do_req(3'd0, 16'h00FE, 16'h0);

    // Error cases: no memory strobes, 1-cycle latency.
    do_req(3'd0, 16'h00FF, 16'h0);
    do_req(3'd7, 16'h0010, 16'h0);
    do_req(3'd5, 16'h0010, 16'h0);
    do_req(3'd1, 16'h0100, 16'h0);
    do_req(3'd3, 16'h00FF, 16'h1111);
    do_req(3'd4, 16'hFFFF, 16'h0022);

    // Random mix, including out-of-range addresses.
    for (int i = 0; i < 24; i++)
      do_req(3'($urandom_range(0, 7)), 16'($urandom_range(0, 260)), 16'($urandom));
    for (int a = 0; a < MB; a++) if (mem[a] !== ref_mem[a]) chk("mem_final", a, 32'hFFFF_FFFF);

    // Reset in the WR cycle of SW 0x1234 @0x30.
    old_hi = mem['h30];
    old_lo = mem['h31];
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 20) begin @(negedge clk); n++; end
    bus.req_valid = 1'b1; bus.req_op = 3'd3; bus.req_addr = 16'h0030; bus.req_wdata = 16'h1234;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    chk("wr_state", bus.mem_write, 1);
    rst = 1'b1;
    #1;
    chk("wr_drop", bus.mem_write, 0);
    chk("wr_rst_ready", bus.req_ready, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("m30_keep", mem['h30], old_hi);
    chk("m31_keep", mem['h31], old_lo);
    chk("ready_after_rst", bus.req_ready, 1);
    repeat (4) @(posedge clk);   // monitor flags any stray response

    // Unit still works after the aborted store.
    do_req(3'd0, 16'h0030, 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout obs=%0d exp=0", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Multi-cycle initiator that sits between the CPU datapath and the byte-addressed, big-endian 16-bit data memory (combinational read of {M[a],M[a+1]}, posedge write of M[a]<=wdata[15:8], M[a+1]<=wdata[7:0]). It accepts one load/store request at a time over a valid/ready handshake and drives the memory's address, write-data, read-strobe and write-strobe inputs. It returns a one-cycle response carrying the load data or an error flag. Byte stores are implemented as read-modify-write, because the memory only writes whole 16-bit words.

## Interface
Parameters:
- MEM_BYTES, 256, number of bytes in the attached memory; valid byte addresses are 0..MEM_BYTES-1.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request; high only in IDLE with rst low.
- req_op  in  3  operation code: 000 LW, 001 LB, 010 LBU, 011 SW, 100 SB; all other codes are illegal.
- req_addr  in  16  byte address.
- req_wdata  in  16  store data; SB uses bits [7:0].
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  16  load result; 0 for stores, errors, and whenever resp_valid is low.
- resp_err  out  1  request rejected; qualified by resp_valid.
- mem_addr  out  16  memory address (DMem_In).
- mem_wdata  out  16  memory write data (Data_Write).
- mem_read  out  1  memory read strobe (Mem_Read).
- mem_write  out  1  memory write strobe (Mem_Write).
- mem_rdata  in  16  memory read data (DataM_out).

## Operation
- **States:**
  - IDLE, RD, WR, RESP.
  - The request is captured on the accepting edge into op_q, addr_q and wdata_q.
- **Base address and lane:**
  - Word ops: base = addr_q.
  - Byte ops with addr_q < MEM_BYTES-1: base = addr_q, lane = high (word bits [15:8]).
  - Byte ops with addr_q = MEM_BYTES-1: base = addr_q-1, lane = low (bits [7:0]).
  - This avoids touching M[MEM_BYTES].
- **Error conditions** (checked at acceptance, no memory access):
  - Illegal op.
  - req_addr >= MEM_BYTES.
  - Word op with req_addr > MEM_BYTES-2.
- **Transitions:**
  - IDLE, req_valid & req_ready:
    - error → RESP with err.
    - LW/LB/LBU/SB → RD.
    - SW → WR.
  - RD: mem_read=1, mem_addr=base; mem_rdata is captured into rbuf at the edge. Loads → RESP; SB → WR.
  - WR: mem_write=1, mem_addr=base.
    - SW: mem_wdata = wdata_q.
    - SB, high lane: mem_wdata = {wdata_q[7:0], rbuf[7:0]}.
    - SB, low lane: mem_wdata = {rbuf[15:8], wdata_q[7:0]}.
    - Next state → RESP.
  - RESP: resp_valid=1 for exactly one cycle, then IDLE. There is no response backpressure.
- **Load results** (registered, presented during RESP):
  - LW: rbuf.
  - LB: selected byte sign-extended to 16 bits.
  - LBU: selected byte zero-extended.
- **Strobe rules:**
  - mem_read and mem_write are decoded from state only and are never high together.
  - mem_addr and mem_wdata are 0 when the corresponding strobe is low.
- **Illegal state encodings** recover to IDLE.

## Timing
- **Reset:** on rst high, immediately go to IDLE and clear all registers.
  - Outputs during reset: req_ready=0, resp_valid=0, resp_err=0, resp_rdata=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
  - Reset during WR drops mem_write combinationally, so no write lands at the next edge.
  - A request in flight when reset asserts is discarded with no response.
- **Latency**, counted from the accepting edge to the cycle in which resp_valid is high:
  - Error: 1 cycle.
  - LW/LB/LBU: 2 cycles.
  - SW: 2 cycles.
  - SB: 3 cycles.
- **Throughput:** req_ready is low from the acceptance edge through RESP. The next request can be accepted in the first IDLE cycle after RESP.
- **Memory interface:** the memory write occurs at the rising edge that ends the WR cycle.
- **Request inputs:** req_op, req_addr and req_wdata are sampled only on the accepting edge. Later changes are ignored.

## Test plan
- SW 0xBEEF @0x0010, then LW @0x0010 → M[0x10]=0xBE, M[0x11]=0xEF; LW resp_rdata=0xBEEF, resp_err=0; both responses arrive 2 cycles after acceptance.
- With the above memory contents, SB 0x5A @0x0011 → RD then WR cycle with mem_addr=0x0011, mem_wdata=0x5A00; subsequent LW @0x0010 → 0xBE5A; SB resp_valid arrives 3 cycles after acceptance.
- With M[0x20]=0x80: LB @0x0020 → 0xFF80; LBU @0x0020 → 0x0080.
- SB 0x77 @0x00FF (MEM_BYTES=256) → mem_addr=0x00FE, M[0xFE] unchanged; LBU @0x00FF → 0x0077; LW @0x00FF → resp_err=1, and no mem_read/mem_write pulses occur.
- Illegal op 3'b111 and LB @0x0100 → each gives resp_valid with resp_err=1 and resp_rdata=0 one cycle after acceptance; no memory strobes.
- rst asserted mid-WR of SW 0x1234 @0x0030 → mem_write falls in the same cycle, M[0x30..0x31] unchanged, no response; req_ready=1 in the first cycle after rst deasserts.
